// File: rtl/pk_pkg.sv
// pk_pkg: shared constants and state encoding for the password-engine command loader
package pk_pkg;
  localparam int KEY_BYTES   = 16;
  localparam int FIELD_BYTES = 16;
  localparam int CMD_BYTES   = 49;
  localparam int RES_BYTES   = 16;
  typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;
endpackage

// File: rtl/pk_serializer.sv
// pk_serializer: streams a 128-bit word MSB-byte first over an 8-bit valid/ready link
module pk_serializer
  import pk_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] data_i,
  output logic [7:0]   out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         last_o
);
  logic [127:0] sh_q, sh_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         vld_q, vld_d;
  logic         fire;
  always_comb begin
    fire   = vld_q && out_ready_i;
    last_o = fire && cnt_q == 4'(RES_BYTES - 1);
    sh_d   = load_i ? data_i : fire ? {sh_q[119:0], 8'h00} : sh_q;
    cnt_d  = load_i ? 4'd0 : fire ? cnt_q + 4'd1 : cnt_q;
    vld_d  = load_i ? 1'b1 : last_o ? 1'b0 : vld_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end
  assign out_data_o  = sh_q[127:120];
  assign out_valid_o = vld_q;
endmodule

// File: rtl/pk_cmd_loader.sv
// pk_cmd_loader: assembles an engine command from a byte stream, starts the engine,
// and returns its 128-bit result as 16 bytes.
module pk_cmd_loader
  import pk_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TCNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] master_key,
  output logic [127:0] account,
  output logic [127:0] password,
  output logic [3:0]   max_address,
  output logic         go,
  input  logic         done,
  input  logic [127:0] password_enc,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         err_timeout
);
  localparam logic [5:0] ACC_END = 6'(KEY_BYTES + FIELD_BYTES);
  localparam logic [5:0] PW_END  = 6'(KEY_BYTES + 2 * FIELD_BYTES);
  localparam logic [5:0] LAST    = 6'(CMD_BYTES - 1);
  state_t              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [127:0]        mk_q, mk_d, acc_q, acc_d, pw_q, pw_d;
  logic [3:0]          ma_q, ma_d;
  logic                done_q, err_q, err_d;
  logic                take, rise, expire, ser_last;
  always_comb begin
    take   = state_q == LOAD && in_valid;
    rise   = done && !done_q;
    expire = state_q == WAIT && !rise && tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1);
    mk_d   = take && cnt_q < 6'(KEY_BYTES) ? {mk_q[119:0], in_data} : mk_q;
    acc_d  = take && cnt_q >= 6'(KEY_BYTES) && cnt_q < ACC_END ? {acc_q[119:0], in_data} : acc_q;
    pw_d   = take && cnt_q >= ACC_END && cnt_q < PW_END ? {pw_q[119:0], in_data} : pw_q;
    ma_d   = take && cnt_q == LAST ? in_data[3:0] : ma_q;
    cnt_d  = !take ? cnt_q : cnt_q == LAST ? 6'd0 : cnt_q + 6'd1;
    tcnt_d = state_q == WAIT ? tcnt_q + TCNT_W'(1) : '0;
    err_d  = err_q || expire;
    state_d = state_q;
    unique case (state_q)
      LOAD:    state_d = take && cnt_q == LAST ? START : LOAD;
      START:   state_d = WAIT;
      WAIT:    state_d = rise ? SEND : expire ? LOAD : WAIT;
      default: state_d = ser_last ? LOAD : SEND;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      mk_q    <= '0;
      acc_q   <= '0;
      pw_q    <= '0;
      ma_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      mk_q    <= mk_d;
      acc_q   <= acc_d;
      pw_q    <= pw_d;
      ma_q    <= ma_d;
      done_q  <= done;
      err_q   <= err_d;
    end
  end
  // The serializer's shift register doubles as the captured result register.
  pk_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (state_q == WAIT && rise),
    .data_i      (password_enc),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .last_o      (ser_last)
  );
  assign in_ready    = state_q == LOAD;
  assign go          = state_q == START;
  assign busy        = state_q != LOAD;
  assign master_key  = mk_q;
  assign account     = acc_q;
  assign password    = pw_q;
  assign max_address = ma_q;
  assign err_timeout = err_q;
endmodule
